leb128_encoder: RTL and testbench
=================================

# leb128_encoder

Streaming serializer that turns a typed 64-bit operand into its WebAssembly immediate byte encoding, one byte per cycle over a valid/ready handshake. It is the write-side counterpart of the CPU's combinational `varintN` decoder. It will be used by the stack dump and trace path to emit `i32.const`/`i64.const`/`f32.const`/`f64.const` immediates in the same byte format the CPU fetches from ROM.

## Interface
- `MAX_BYTES`, default 10: byte-count ceiling and width of the internal counter; 10 covers 64-bit LEB128.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `in_valid` input 1: operand offered.
- `in_ready` output 1: encoder idle and able to accept.
- `in_value` input 64: operand; for i32/f32 only `[31:0]` is used.
- `in_type` input 2: operand type, using the shared i32/i64/f32/f64 type codes.
- `in_signed` input 1: 1 selects signed LEB128, 0 selects unsigned; ignored for f32/f64.
- `out_valid` output 1: `out_byte` valid.
- `out_ready` input 1: sink consumes the byte.
- `out_byte` output 8: encoded byte.
- `out_last` output 1: current byte ends the sequence.
- `out_len` output 4: 1-based index of the current byte within its sequence.

## Operation
- States: IDLE and EMIT.
  - `in_ready` = (state == IDLE).
  - All other outputs are registered.
- **IDLE:** on `in_valid && in_ready`, latch the operand into a 64-bit shift register `sr`, then go to EMIT.
  - i32 signed: sign-extend `in_value[31:0]`.
  - i32 unsigned: zero-extend `in_value[31:0]`.
  - i64: take all 64 bits.
  - f32/f64: take the raw bits.
  - Set mode (LEB or RAW), byte limit (i32 5, i64 10, f32 4, f64 8) and count = 1.
- **EMIT, LEB mode:**
  - `g = sr[6:0]`.
  - `rest` = `sr` shifted right by 7, arithmetic if signed, logical if unsigned.
  - Unsigned: last = (`rest` == 0).
  - Signed: last = (`rest` == 0 && !`g[6]`) || (`rest` == all-ones && `g[6]`).
  - last is also forced when count == limit.
  - `out_byte` = {!last, g}.
- **EMIT, RAW mode:**
  - `out_byte` = `sr[7:0]`, little-endian; `sr` shifts right by 8.
  - last = (count == limit); the MSB is not a continuation flag.
- On `out_valid && out_ready`:
  - Not last: load `rest` into `sr`, count++, present the next byte.
  - Last: return to IDLE and deassert `out_valid`.
- While `out_valid && !out_ready`, `out_byte`, `out_last` and `out_len` hold stable.
- `in_valid` is ignored outside IDLE. Operand inputs are sampled only on the accept cycle.
- f32/f64 with `in_signed` set: `in_signed` is ignored.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `out_byte` 0x00, `out_last` 0, `out_len` 0, `sr` 0.
- Accept at cycle N puts the first byte on the outputs at N+1.
- With `out_ready` held high, a k-byte sequence occupies cycles N+1..N+k. `in_ready` rises at N+k+1, so there is one idle bubble between operands.
- Throughput is 1 byte/cycle inside a sequence.
- Backpressure adds cycles one-for-one and never drops or duplicates a byte.
- Reset mid-sequence: the next cycle shows reset values. The partial sequence is abandoned with no `out_last`, and no byte is pending after reset.
- Reset asserted in the same cycle as an accept: reset wins and the operand is discarded.

## Structure
- Shared package contents: type codes (shared with the stack entry format), the IDLE/EMIT state encoding, and the per-type byte limits (5/10/4/8).
- One natural sub-module, `leb128_enc_step`. It is combinational: given `sr`, mode and signedness, it produces `g`, `rest` and last.
- The FSM, counter and handshake stay in `leb128_encoder`.

## Test plan
- Unsigned i32 624485 (0x98765) → E5 8E 26; `out_last` on byte 3; `out_len` 1, 2, 3.
- Signed i64 −123456 → C0 BB 78.
- Signed i32 with `in_value` = 0xDEADBEEF_80000000 → 80 80 80 80 78; the upper word is ignored.
- Single-byte cases:
  - Signed i32 −1 → 7F.
  - Unsigned i64 0 → 00.
  - Signed i64 64 → C0 00.
- Unsigned i64 0xFFFF_FFFF_FFFF_FFFF → FF ×9 then 01 with `out_len` = 10. Follow with a back-to-back operand: `in_ready` low during the sequence, high exactly one cycle after the last handshake.
- Backpressure and RAW mode: f32 0x3F800000 with `out_ready` low for 3 cycles at byte 2 → 00 00 80 3F, byte 2 held stable during the stall. Then assert `reset` mid-sequence of f64 0x400921FB54442D18 → next cycle `out_valid` 0 and `in_ready` 1, with no `out_last` seen.

Source files
------------

// File: rtl/leb128_encoder_pkg.sv
// Shared definitions for the immediate-byte encoder: operand type codes,
// FSM/mode encodings and the per-type byte ceilings.
package leb128_encoder_pkg;

    typedef enum logic [1:0] {
        TYPE_I32 = 2'd0,
        TYPE_I64 = 2'd1,
        TYPE_F32 = 2'd2,
        TYPE_F64 = 2'd3
    } val_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } enc_state_e;

    typedef enum logic {
        MODE_LEB = 1'b0,
        MODE_RAW = 1'b1
    } enc_mode_e;

    localparam int LIMIT_I32 = 5;
    localparam int LIMIT_I64 = 10;
    localparam int LIMIT_F32 = 4;
    localparam int LIMIT_F64 = 8;

    function automatic int type_limit(input val_type_e t);
        case (t)
            TYPE_I32: return LIMIT_I32;
            TYPE_I64: return LIMIT_I64;
            TYPE_F32: return LIMIT_F32;
            default:  return LIMIT_F64;
        endcase
    endfunction

    function automatic logic is_float(input val_type_e t);
        return (t == TYPE_F32) || (t == TYPE_F64);
    endfunction

endpackage

// File: rtl/leb128_enc_step.sv
// One serialisation step: splits the pending value into the next payload
// byte and the remainder, and flags when the value is exhausted.
module leb128_enc_step
    import leb128_encoder_pkg::*;
(
    input  logic [63:0] sr,
    input  enc_mode_e   mode,
    input  logic        is_signed,
    output logic [7:0]  g,
    output logic [63:0] rest,
    output logic        last
);

    always_comb begin
        g    = 8'h00;
        rest = 64'h0;
        last = 1'b0;
        if (mode == MODE_RAW) begin
            // Raw float bytes end only on the byte budget, decided by the caller.
            g    = sr[7:0];
            rest = {8'h00, sr[63:8]};
        end else begin
            g = {1'b0, sr[6:0]};
            if (is_signed) begin
                rest = {{7{sr[63]}}, sr[63:7]};
                // Done once the remainder is pure sign and bit 6 already carries it.
                last = ((rest == 64'h0) && !sr[6]) || ((rest == '1) && sr[6]);
            end else begin
                rest = {7'h00, sr[63:7]};
                last = (rest == 64'h0);
            end
        end
    end

endmodule

// File: rtl/leb128_encoder.sv
// Streaming encoder for i32/i64/f32/f64 immediates: LEB128 for integers,
// little-endian raw bytes for floats, one byte per cycle over valid/ready.
module leb128_encoder
    import leb128_encoder_pkg::*;
#(
    parameter int MAX_BYTES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_value,
    input  logic [1:0]  in_type,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic [3:0]  out_len
);

    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    enc_state_e       state_q, state_d;
    logic [63:0]      sr_q, sr_d;
    enc_mode_e        mode_q, mode_d;
    logic             signed_q, signed_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_last_q, out_last_d;
    logic [3:0]       out_len_q, out_len_d;

    val_type_e        in_type_e;
    logic             in_float;
    logic [63:0]      in_ext;
    logic             load;
    logic [63:0]      src_value;
    enc_mode_e        src_mode;
    logic             src_signed;
    logic [CNT_W-1:0] src_limit;
    logic [CNT_W-1:0] src_count;
    logic [7:0]       step_g;
    logic [63:0]      step_rest;
    logic             step_last;
    logic             byte_last;

    function automatic logic [CNT_W-1:0] clamp_limit(input val_type_e t);
        int l;
        l = type_limit(t);
        if (l > MAX_BYTES) begin
            l = MAX_BYTES;
        end
        return CNT_W'(l);
    endfunction

    assign in_type_e = val_type_e'(in_type);
    assign in_float  = is_float(in_type_e);

    always_comb begin
        case (in_type_e)
            TYPE_I32: in_ext = in_signed ? {{32{in_value[31]}}, in_value[31:0]}
                                         : {32'h0, in_value[31:0]};
            TYPE_F32: in_ext = {32'h0, in_value[31:0]};
            default:  in_ext = in_value;
        endcase
    end

    // sr holds only the bytes not yet presented, so the step always runs on
    // whatever the next registered byte is built from: the fresh operand on
    // accept, the stored remainder on advance.
    always_comb begin
        load       = 1'b0;
        src_value  = sr_q;
        src_mode   = mode_q;
        src_signed = signed_q;
        src_limit  = limit_q;
        src_count  = count_q + CNT_W'(1);
        if (state_q == ST_IDLE) begin
            load       = in_valid;
            src_value  = in_ext;
            src_mode   = in_float ? MODE_RAW : MODE_LEB;
            src_signed = in_signed && !in_float;
            src_limit  = clamp_limit(in_type_e);
            src_count  = CNT_W'(1);
        end else begin
            load = out_ready && !out_last_q;
        end
    end

    leb128_enc_step u_step (
        .sr        (src_value),
        .mode      (src_mode),
        .is_signed (src_signed),
        .g         (step_g),
        .rest      (step_rest),
        .last      (step_last)
    );

    assign byte_last = step_last || (src_count == src_limit);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        mode_d      = mode_q;
        signed_d    = signed_q;
        limit_d     = limit_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        out_last_d  = out_last_q;
        out_len_d   = out_len_q;
        if (load) begin
            state_d     = ST_EMIT;
            sr_d        = step_rest;
            mode_d      = src_mode;
            signed_d    = src_signed;
            limit_d     = src_limit;
            count_d     = src_count;
            out_valid_d = 1'b1;
            out_byte_d  = (src_mode == MODE_RAW) ? step_g : {!byte_last, step_g[6:0]};
            out_last_d  = byte_last;
            out_len_d   = 4'(src_count);
        end else if ((state_q == ST_EMIT) && out_ready && out_last_q) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sr_q        <= 64'h0;
            mode_q      <= MODE_LEB;
            signed_q    <= 1'b0;
            limit_q     <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
            out_last_q  <= 1'b0;
            out_len_q   <= 4'h0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            mode_q      <= mode_d;
            signed_q    <= signed_d;
            limit_q     <= limit_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_last_q  <= out_last_d;
            out_len_q   <= out_len_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign out_last  = out_last_q;
    assign out_len   = out_len_q;

endmodule

// File: tb/tb_leb128_encoder.sv
// Directed bench: expected bytes are queued when an operand is offered and a
// monitor compares each presented byte (including stalled ones) against the queue head.
module tb_leb128_encoder;
    import leb128_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_value;
    logic [1:0]  in_type;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic [3:0]  out_len;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
        logic [3:0] len;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_hs_cyc = 0;
    string tag = "reset";

    leb128_encoder #(.MAX_BYTES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_type   (in_type),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .out_len   (out_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s/%s actual %0h required %0h", tag, nm, act, req);
        end
    endtask

    task automatic push_seq(input logic [79:0] bytes, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.b    = bytes[8*i +: 8];
            e.last = (i == n - 1);
            e.len  = 4'(i + 1);
            sb.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s/unexpected_byte actual %02h required none", tag, out_byte);
                end else begin
                    e = sb[0];
                    chk("byte", 64'(out_byte), 64'(e.b));
                    chk("last", 64'(out_last), 64'(e.last));
                    chk("len", 64'(out_len), 64'(e.len));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        if (out_last) last_hs_cyc = cyc;
                    end
                end
            end
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic offer(input logic [63:0] v, input logic [1:0] t, input logic s,
                         output int acc_cyc, output int wait_cycles);
        in_value  = v;
        in_type   = t;
        in_signed = s;
        in_valid  = 1'b1;
        wait_cycles = 0;
        acc_cyc = -1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            wait_cycles++;
            if (wait_cycles > 200) begin
                chk("in_ready_timeout", 64'(0), 64'(1));
                in_valid = 1'b0;
                return;
            end
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
        $display("op %s: value=%016h type=%0d signed=%0d accepted at cycle %0d", tag, v, t, s, acc_cyc);
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || out_valid) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) chk("drain_timeout", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string nm, input logic [63:0] v, input logic [1:0] t,
                          input logic s, input logic [79:0] bytes, input int n);
        int a, w;
        tag = nm;
        push_seq(bytes, n);
        offer(v, t, s, a, w);
        drain();
    endtask

    initial begin
        int acc0, acc1, w0, w1;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_value  = 64'h0;
        in_type   = 2'd0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_byte", 64'(out_byte), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_out_len", 64'(out_len), 64'(0));
        @(posedge clk);
        #1;

        run_op("u32_624485", 64'h98765, TYPE_I32, 1'b0, {8'h26, 8'h8E, 8'hE5}, 3);
        run_op("s64_m123456", 64'hFFFF_FFFF_FFFE_1DC0, TYPE_I64, 1'b1, {8'h78, 8'hBB, 8'hC0}, 3);
        run_op("s32_min_upper_ignored", 64'hDEADBEEF_80000000, TYPE_I32, 1'b1,
               {8'h78, 8'h80, 8'h80, 8'h80, 8'h80}, 5);
        run_op("s32_m1", 64'h0000_0000_FFFF_FFFF, TYPE_I32, 1'b1, {8'h7F}, 1);
        run_op("u64_0", 64'h0, TYPE_I64, 1'b0, {8'h00}, 1);
        run_op("s64_64", 64'd64, TYPE_I64, 1'b1, {8'h00, 8'hC0}, 2);

        // Ten-byte maximum followed by an operand already waiting on in_valid.
        tag = "u64_max";
        push_seq({8'h01, {9{8'hFF}}}, 10);
        push_seq({8'h05}, 1);
        offer(64'hFFFF_FFFF_FFFF_FFFF, TYPE_I64, 1'b0, acc0, w0);
        tag = "b2b_u64_5";
        offer(64'd5, TYPE_I64, 1'b0, acc1, w1);
        chk("ready_low_cycles", 64'(w1), 64'(10));
        chk("accept_gap", 64'(acc1 - acc0), 64'(11));
        chk("accept_after_last", 64'(acc1), 64'(last_hs_cyc + 1));
        drain();

        // Raw float with a three-cycle stall on byte 2; in_signed must be ignored.
        tag = "f32_stall";
        push_seq({8'h3F, 8'h80, 8'h00, 8'h00}, 4);
        offer(64'h3F80_0000, TYPE_F32, 1'b1, acc0, w0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset while the fourth f64 byte is on the outputs.
        tag = "f64_reset";
        push_seq({16'h0, 64'h400921FB54442D18}, 8);
        offer(64'h400921FB54442D18, TYPE_F64, 1'b0, acc0, w0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(out_valid), 64'(0));
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        chk("post_rst_out_last", 64'(out_last), 64'(0));
        chk("post_rst_out_len", 64'(out_len), 64'(0));
        @(posedge clk);
        #1;

        // Accept coinciding with reset: operand must be dropped.
        tag = "accept_during_reset";
        in_value  = 64'h98765;
        in_type   = TYPE_I32;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        reset     = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(0));
        chk("in_ready", 64'(in_ready), 64'(1));
        repeat (3) @(negedge clk);
        chk("still_idle", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;

        run_op("u32_after_reset", 64'h98765, TYPE_I32, 1'b0, {8'h26, 8'h8E, 8'hE5}, 3);

        tag = "end";
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
